// File: rtl/kontrolluesi_mbledhjes_seriale_if.sv
// Handshake/bus bundle for the bit-serial add/subtract sequencer.
//   i_start    : request, sampled only while the sequencer is idle
//   i_op       : 0 = A+B, 1 = A-B (captured with the operands)
//   i_a, i_b   : WIDTH-bit operands, captured on the accepting edge
//   o_busy     : high while an operation is in progress
//   o_done     : one-cycle pulse, result and flags just updated
//   o_result   : last completed result, held until the next completion
//   o_cout     : final carry out (subtract: 1 = no borrow)
//   o_overflow : signed overflow of the last operation
//   o_zero     : o_result == 0
// master = requester side, slave = sequencer side.
interface kontrolluesi_mbledhjes_seriale_if #(
  parameter int WIDTH = 24
);
  logic             i_start;
  logic             i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic             o_cout;
  logic             o_overflow;
  logic             o_zero;

  modport master (
    output i_start, i_op, i_a, i_b,
    input  o_busy, o_done, o_result, o_cout, o_overflow, o_zero
  );

  modport slave (
    input  i_start, i_op, i_a, i_b,
    output o_busy, o_done, o_result, o_cout, o_overflow, o_zero
  );
endinterface

// File: rtl/kontrolluesi_mbledhjes_seriale.sv
// Bit-serial add/subtract sequencer. One full-adder cell is reused over
// WIDTH cycles, LSB first, to form A+B or A-B (A + ~B + 1).
// Ports:
//   i_clk : rising-edge clock
//   i_rst : asynchronous active-high reset
//   bus   : slave side of kontrolluesi_mbledhjes_seriale_if
//           (start/op/A/B in; busy/done/result/cout/overflow/zero out)
module kontrolluesi_mbledhjes_seriale #(
  parameter int WIDTH = 24
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  kontrolluesi_mbledhjes_seriale_if.slave    bus
);
  localparam int                CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic             w_accept, w_last;

  logic [WIDTH-1:0] r_sa, r_sb, r_sr;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout, r_ovf, r_done;

  // Shared full-adder cell.
  logic             w_sum, w_cout;
  logic [WIDTH-1:0] w_sr_nxt;

  assign w_sum    = r_sa[0] ^ r_sb[0] ^ r_c;
  assign w_cout   = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_c) | (r_sb[0] & r_c);
  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at [0].
  assign w_sr_nxt = {w_sum, r_sr[WIDTH-1:1]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: if (bus.i_start) begin
        w_accept    = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: if (r_cnt == LAST) begin
        w_last      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_sr     <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_sa  <= bus.i_a;
        // Subtract as A + ~B with the +1 injected through the initial carry.
        r_sb  <= bus.i_op ? ~bus.i_b : bus.i_b;
        r_c   <= bus.i_op;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_sr  <= w_sr_nxt;
        r_c   <= w_cout;
        r_sa  <= r_sa >> 1;
        r_sb  <= r_sb >> 1;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_result <= w_sr_nxt;
          r_cout   <= w_cout;
          // Signed overflow: carry into the MSB differs from carry out of it.
          r_ovf    <= r_c ^ w_cout;
        end
      end
    end
  end

  assign bus.o_busy     = (r_state == S_RUN);
  assign bus.o_done     = r_done;
  assign bus.o_result   = r_result;
  assign bus.o_cout     = r_cout;
  assign bus.o_overflow = r_ovf;
  assign bus.o_zero     = (r_result == '0);
endmodule

// File: tb/tb_kontrolluesi_mbledhjes_seriale.sv
module tb_kontrolluesi_mbledhjes_seriale;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  kontrolluesi_mbledhjes_seriale_if #(.WIDTH(W)) bus ();

  kontrolluesi_mbledhjes_seriale #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         z;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference: plain wide arithmetic, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic op);
    exp_t         e;
    logic [W:0]   full;
    logic [W-1:0] bb;
    bb    = op ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, op};
    e.res = full[W-1:0];
    e.co  = full[W];
    if (op) e.ov = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
    else    e.ov = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
    e.z   = (e.res == '0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; accept happens on the following posedge.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic op, input bit push);
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_op    = op;
    bus.i_start = 1'b1;
    if (push) q.push_back(model(a, b, op));
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    // Scramble operands during RUN; they must have no effect.
    bus.i_a     = W'($urandom);
    bus.i_b     = W'($urandom);
    bus.i_op    = 1'($urandom_range(0, 1));
    chk("busy_after_accept", {31'd0, bus.o_busy}, 32'd1);
  endtask

  // Waits (bounded) for done; returns at the negedge inside the done cycle.
  task automatic wait_done(input int c0, input int exp_lat, output int lat);
    int   cyc;
    int   bc;
    exp_t e;
    cyc = c0;
    bc  = c0;
    while (!bus.o_done && cyc < 60) begin
      if (bus.o_busy) bc++;
      @(negedge clk);
      cyc++;
    end
    lat = cyc;
    chk("done_seen", {31'd0, bus.o_done}, 32'd1);
    if (bus.o_done) begin
      if (exp_lat > 0) begin
        chk("latency", cyc, exp_lat);
        chk("busy_cycles", bc, exp_lat);
      end
      chk("busy_in_done", {31'd0, bus.o_busy}, 32'd0);
      n_cmp++;
      assert (q.size() > 0) else begin
        n_err++;
        $error("FAIL sb_underflow: observed done with %0d expected entries", q.size());
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("result",   {8'd0, bus.o_result},    {8'd0, e.res});
        chk("cout",     {31'd0, bus.o_cout},     {31'd0, e.co});
        chk("overflow", {31'd0, bus.o_overflow}, {31'd0, e.ov});
        chk("zero",     {31'd0, bus.o_zero},     {31'd0, e.z});
      end
    end
  endtask

  logic [W-1:0] ta[5] = '{24'hFFFFFF, 24'h7FFFFF, 24'h000005, 24'h800000, 24'h123456};
  logic [W-1:0] tb[5] = '{24'h000001, 24'h000001, 24'h000007, 24'h000001, 24'h123456};
  logic         top[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int lat;
    bit seen;
    bus.i_start = 1'b0;
    bus.i_op    = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("rst_busy",     {31'd0, bus.o_busy},     32'd0);
    chk("rst_done",     {31'd0, bus.o_done},     32'd0);
    chk("rst_result",   {8'd0, bus.o_result},    32'd0);
    chk("rst_cout",     {31'd0, bus.o_cout},     32'd0);
    chk("rst_overflow", {31'd0, bus.o_overflow}, 32'd0);
    chk("rst_zero",     {31'd0, bus.o_zero},     32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Simple add, done width and latency.
    drive_start(24'h000001, 24'h000002, 1'b0, 1'b1);
    wait_done(0, W, lat);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, bus.o_done}, 32'd0);

    // Carry, overflow and subtract corners.
    for (int i = 0; i < 5; i++) begin
      drive_start(ta[i], tb[i], top[i], 1'b1);
      wait_done(0, W, lat);
      @(negedge clk);
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    drive_start(24'h00ABCD, 24'h001111, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("busy_mid_run", {31'd0, bus.o_busy}, 32'd1);
    bus.i_a     = 24'h333333;
    bus.i_b     = 24'h444444;
    bus.i_op    = 1'b1;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_done(11, W, lat);
    drive_start(24'h000100, 24'h000FFF, 1'b1, 1'b1);
    wait_done(0, W, lat);
    chk("done_to_done", lat + 1, W + 1);
    @(negedge clk);

    // Reset mid-operation aborts with no done and no result update.
    drive_start(24'h000001, 24'h000002, 1'b0, 1'b1);
    wait_done(0, W, lat);
    @(negedge clk);
    drive_start(24'h000456, 24'h000123, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy",   {31'd0, bus.o_busy},  32'd0);
    chk("abort_done",   {31'd0, bus.o_done},  32'd0);
    chk("abort_result", {8'd0, bus.o_result}, 32'd0);
    chk("abort_zero",   {31'd0, bus.o_zero},  32'd1);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.o_done) seen = 1'b1;
    end
    chk("abort_no_done",   {31'd0, seen},        32'd0);
    chk("abort_result_hold", {8'd0, bus.o_result}, 32'd0);
    drive_start(24'h00000A, 24'h000005, 1'b0, 1'b1);
    wait_done(0, W, lat);
    chk("fresh_result", {8'd0, bus.o_result}, 32'h0000000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/kontrolluesi_mbledhjes_seriale.md
# kontrolluesi_mbledhjes_seriale

Bit-serial add/subtract sequencer that time-shares a single one-bit full-adder cell (SUM = A^B^CIN, COUT = majority(A,B,CIN)) to compute a WIDTH-bit sum or difference over WIDTH clock cycles. It is the area-reduced alternative to the parallel ripple adder in the CPU datapath, for multi-cycle ALU operations and address computations. It owns operand capture, carry sequencing, the bit counter, result assembly and status flags.

## Interface
- WIDTH, 24, operand/result width in bits (≥2).
- Clock  input  1  rising-edge clock; the only clock.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- op  input  1  0 = A+B, 1 = A−B; captured with operands.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: result and flags just updated.
- result  output  WIDTH  last completed result; held until the next completion.
- cout  output  1  final carry out; for subtract, 1 = no borrow.
- overflow  output  1  signed overflow of the last operation.
- zero  output  1  result == 0, derived from the registered result.

## Operation
- States: IDLE, RUN. Bit counter cnt with width $clog2(WIDTH).
- IDLE: on an edge with start=1, do all of the following, then go to RUN:
  - latch A into shift register sa;
  - latch (op ? ~B : B) into sb;
  - set carry register c = op;
  - clear cnt.
- IDLE with start=0: nothing changes.
- RUN, each edge, feed the cell sa[0], sb[0] and c, then:
  - shift the cell SUM into the MSB of internal shift register sr (right shift);
  - c ← cell COUT;
  - right-shift sa and sb;
  - cnt++.
- RUN, on the edge where cnt == WIDTH−1 (the MSB is processed):
  - result ← final sr value, including this bit;
  - cout ← cell COUT;
  - overflow ← cell CIN ^ cell COUT for the MSB bit;
  - done ← 1;
  - state → IDLE.
- Internal sr never drives result directly. result, cout and overflow change only at completion.
- Subtract is two's complement: A + ~B + 1.
- Arithmetic is modulo 2^WIDTH. The carry-out is reported only through cout.
- start while busy=1: ignored; no queuing.
- start in the done cycle: accepted, because the state is IDLE.
- A, B and op changing during RUN: no effect.
- Reset, at any time, including mid-RUN:
  - state = IDLE, busy = 0, done = 0;
  - result = 0, cout = 0, overflow = 0, zero = 1;
  - the aborted operation produces no done and no result update.

## Timing
- Let E0 be the accepting edge.
- busy = (state == RUN): high from E0 until E0+WIDTH, i.e. exactly WIDTH cycles.
- Bit i is computed at edge E0+1+i.
- result and flags update at edge E0+WIDTH.
- done is high for exactly the one cycle after E0+WIDTH, while busy = 0.
- Latency from start to done is WIDTH cycles (24 at the default).
- The earliest next accept is at edge E0+WIDTH+1, giving back-to-back throughput of WIDTH+1 cycles per operation.
- done is registered, with no combinational path from start to any output.
- zero follows result combinationally, so it is valid in the same cycle as done.

## Test plan
- Reset: assert Reset mid-cycle with no clock edge, then release.
  - Required: busy=0, done=0, result=0x000000, cout=0, overflow=0, zero=1, all immediately.
- Add: A=0x000001, B=0x000002, op=0.
  - Required: done exactly 24 cycles after the accept edge; result=0x000003, cout=0, overflow=0, zero=0; busy high for 24 cycles.
- Add with carry and sign overflow:
  - 0xFFFFFF+0x000001 → result 0x000000, cout=1, zero=1, overflow=0.
  - 0x7FFFFF+0x000001 → result 0x800000, cout=0, overflow=1.
- Subtract:
  - 0x000005−0x000007 → 0xFFFFFE, cout=0, overflow=0.
  - 0x800000−0x000001 → 0x7FFFFF, cout=1, overflow=1.
  - 0x123456−0x123456 → 0x000000, zero=1, cout=1.
- Start while busy and back-to-back:
  - Pulse start with new operands at cycle 10 of RUN → ignored; result matches the first operation.
  - Start in the done cycle → accepted; second done 25 cycles after the first.
- Reset mid-operation:
  - Complete 0x000003 first, then start a new operation and assert Reset at cnt=10.
  - Required: no done pulse; result=0; after release, a fresh 0x00000A+0x000005 yields 0x00000F.
